// File: rtl/conv2_relu_pool.sv
// conv2_relu_pool: ReLU + requantize + 2x2 stride-2 max pooling on a raster
// stream of signed conv2 results. Emits one unsigned pooled activation per
// 2x2 window, one cycle after the window's bottom-right sample is accepted.
module conv2_relu_pool #(
   parameter int unsigned IN_W  = 14,
   parameter int unsigned OUT_W = 8,
   parameter int unsigned SHIFT = 2,
   parameter int unsigned MAP_W = 8,
   parameter int unsigned MAP_H = 8,
   localparam int unsigned NOUT  = (MAP_W / 2) * (MAP_H / 2),
   localparam int unsigned IDX_W = (NOUT > 1) ? $clog2(NOUT) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic signed [IN_W-1:0] in_data,
   output logic                   out_valid,
   output logic [OUT_W-1:0]       out_data,
   output logic [IDX_W-1:0]       out_idx,
   output logic                   frame_done
);

   localparam int unsigned COL_W = $clog2(MAP_W);
   localparam int unsigned ROW_W = $clog2(MAP_H);
   localparam int unsigned HC_W  = (MAP_W > 2) ? $clog2(MAP_W / 2) : 1;
   localparam int unsigned LB_N  = 1 << HC_W;
   localparam int unsigned WW    = (IN_W > OUT_W) ? IN_W : OUT_W + 1;

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [IDX_W-1:0] oidx_q, oidx_d;
   logic [OUT_W-1:0] hmax_q, hmax_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic             frame_done_q, frame_done_d;

   logic [OUT_W-1:0] lbuf_q [LB_N];

   logic signed [IN_W-1:0] shr_s;
   logic [WW-1:0]          shr_w;
   logic [OUT_W-1:0]       q;
   logic [OUT_W-1:0]       hpair;
   logic [OUT_W-1:0]       lb_rd;
   logic [OUT_W-1:0]       wmax;
   logic [HC_W-1:0]        hidx;
   logic                   col_last;
   logic                   row_last;

   // ReLU, arithmetic right shift and unsigned saturation, then pair/window maxima
   always_comb begin
      shr_s = in_data >>> SHIFT;
      shr_w = WW'($unsigned(shr_s));
      q     = '0;
      if (!in_data[IN_W-1] && (in_data != '0)) begin
         if (shr_w > WW'({OUT_W{1'b1}})) begin
            q = '1;
         end else begin
            q = shr_w[OUT_W-1:0];
         end
      end
      hidx     = HC_W'(col_q >> 1);
      hpair    = (q > hmax_q) ? q : hmax_q;
      lb_rd    = lbuf_q[hidx];
      wmax     = (lb_rd > hpair) ? lb_rd : hpair;
      col_last = (col_q == COL_W'(MAP_W - 1));
      row_last = (row_q == ROW_W'(MAP_H - 1));
   end

   // Next-state: raster counters, horizontal max and the pooled output strobe
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      oidx_d       = oidx_q;
      hmax_d       = hmax_q;
      out_valid_d  = 1'b0;
      out_data_d   = out_data_q;
      out_idx_d    = out_idx_q;
      frame_done_d = 1'b0;
      if (in_valid) begin
         if (!col_q[0]) begin
            hmax_d = q;
         end else if (row_q[0]) begin
            out_valid_d  = 1'b1;
            out_data_d   = wmax;
            out_idx_d    = oidx_q;
            frame_done_d = col_last && row_last;
            oidx_d       = (col_last && row_last) ? '0 : oidx_q + IDX_W'(1);
         end
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         oidx_q       <= '0;
         hmax_q       <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_idx_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         oidx_q       <= oidx_d;
         hmax_q       <= hmax_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_idx_q    <= out_idx_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line buffer holds even-row pair maxima; odd rows read it combinationally,
   // so a row-0 write of the next frame never disturbs the previous frame's
   // final window, whose value was captured at its own accepting edge
   always_ff @(posedge clk) begin
      if (rst_n && in_valid && col_q[0] && !row_q[0]) begin
         lbuf_q[hidx] <= hpair;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_idx    = out_idx_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv2_relu_pool.sv
// Testbench for conv2_relu_pool: directed and random frames compared against
// an array-based reference of ReLU/requantize/2x2 max pooling.
module tb_conv2_relu_pool;

   localparam int unsigned IN_W  = 14;
   localparam int unsigned OUT_W = 8;
   localparam int unsigned SHIFT = 2;
   localparam int unsigned MAP_W = 8;
   localparam int unsigned MAP_H = 8;
   localparam int unsigned IDX_W = 4;
   localparam int          QMAX  = (1 << OUT_W) - 1;

   typedef struct {
      int data;
      int idx;
      int fd;
      int t;
   } ev_t;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   in_valid = 1'b0;
   logic signed [IN_W-1:0] in_data = '0;
   logic                   out_valid;
   logic [OUT_W-1:0]       out_data;
   logic [IDX_W-1:0]       out_idx;
   logic                   frame_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   ev_t exp_q[$];
   ev_t obs_q[$];

   // reference model state: current raster position and requantized frame
   int mr = 0;
   int mc = 0;
   int qv [MAP_H][MAP_W];

   logic [OUT_W-1:0] last_data = '0;
   logic [IDX_W-1:0] last_idx = '0;

   conv2_relu_pool #(
      .IN_W (IN_W),
      .OUT_W(OUT_W),
      .SHIFT(SHIFT),
      .MAP_W(MAP_W),
      .MAP_H(MAP_H)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Collect strobes; between strobes outputs must hold and frame_done stay low
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         obs_q.push_back('{data: int'(out_data), idx: int'(out_idx),
                           fd: int'(frame_done), t: cyc});
         last_data = out_data;
         last_idx  = out_idx;
      end else if (rst_n === 1'b1) begin
         checks++;
         assert (out_data === last_data && out_idx === last_idx && frame_done === 1'b0)
         else begin
            errors++;
            $error("FAIL hold: observed data=%0d idx=%0d fd=%b, expected data=%0d idx=%0d fd=0",
                   out_data, out_idx, frame_done, last_data, last_idx);
         end
      end else begin
         last_data = '0;
         last_idx  = '0;
      end
   end

   function automatic int requant(input int v);
      int s;
      if (v <= 0) return 0;
      s = v / (1 << SHIFT);
      return (s > QMAX) ? QMAX : s;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic send(input int v);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = IN_W'(v);
      qv[mr][mc] = requant(v);
      if ((mr % 2 == 1) && (mc % 2 == 1)) begin
         exp_q.push_back('{data: max2(max2(qv[mr-1][mc-1], qv[mr-1][mc]),
                                      max2(qv[mr][mc-1], qv[mr][mc])),
                           idx: (mr / 2) * (MAP_W / 2) + mc / 2,
                           fd: (mr == MAP_H - 1 && mc == MAP_W - 1) ? 1 : 0,
                           t: cyc + 1});
      end
      if (mc == MAP_W - 1) begin
         mc = 0;
         mr = (mr == MAP_H - 1) ? 0 : mr + 1;
      end else begin
         mc = mc + 1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_data  = IN_W'($urandom);
      end
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mr = 0;
      mc = 0;
   endtask

   // kind: 0 ramp, 1 constant -100, 2 saturating corner, 3 random
   // gap: 0 none, 1 three idles per sample plus a row-boundary gap, 2 random
   task automatic send_frame(input int kind, input int gap, input int nsamp);
      int n;
      int v;
      n = 0;
      for (int r = 0; r < int'(MAP_H); r++) begin
         for (int c = 0; c < int'(MAP_W); c++) begin
            if (n < nsamp) begin
               case (kind)
                  0:       v = 4 * (r * int'(MAP_W) + c);
                  1:       v = -100;
                  2:       v = (r == 0 && c == 0) ? 8191 : 0;
                  default: v = int'($urandom_range(0, 16383)) - 8192;
               endcase
               send(v);
               if (gap == 1) begin
                  idle(3);
                  if (r == 3 && c == int'(MAP_W) - 1) idle(10);
               end else if (gap == 2) begin
                  idle(int'($urandom_range(0, 2)));
               end
               n++;
            end
         end
      end
   endtask

   task automatic drain_and_check(input string tag);
      ev_t e;
      ev_t o;
      idle(4);
      checks++;
      assert (obs_q.size() === exp_q.size())
      else begin
         errors++;
         $error("FAIL %s count: observed %0d strobes, expected %0d", tag, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         assert (o.data === e.data && o.idx === e.idx && o.fd === e.fd && o.t === e.t)
         else begin
            errors++;
            $error("FAIL %s: observed data=%0d idx=%0d fd=%0d t=%0d, expected data=%0d idx=%0d fd=%0d t=%0d",
                   tag, o.data, o.idx, o.fd, o.t, e.data, e.idx, e.fd, e.t);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      do_reset(3);
      @(negedge clk);
      checks++;
      assert (out_valid === 1'b0) else begin
         errors++; $error("FAIL reset_valid: observed %b, expected 0", out_valid);
      end
      checks++;
      assert (out_data === '0) else begin
         errors++; $error("FAIL reset_data: observed %0d, expected 0", out_data);
      end
      checks++;
      assert (out_idx === '0) else begin
         errors++; $error("FAIL reset_idx: observed %0d, expected 0", out_idx);
      end
      checks++;
      assert (frame_done === 1'b0) else begin
         errors++; $error("FAIL reset_done: observed %b, expected 0", frame_done);
      end

      send_frame(0, 0, 64);
      drain_and_check("ramp");

      send_frame(1, 0, 64);
      drain_and_check("negative");

      send_frame(2, 0, 64);
      drain_and_check("saturate");

      send_frame(0, 1, 64);
      drain_and_check("ramp_gaps");

      send_frame(0, 0, 64);
      send_frame(0, 0, 64);
      drain_and_check("back_to_back");

      send_frame(0, 0, 20);
      idle(1);
      drain_and_check("partial");
      do_reset(1);
      send_frame(0, 0, 64);
      drain_and_check("after_reset");

      for (int k = 0; k < 3; k++) begin
         send_frame(3, 2, 64);
         drain_and_check("random");
      end
      send_frame(3, 0, 64);
      send_frame(3, 0, 64);
      drain_and_check("random_b2b");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
